// File: rtl/sram_mem_controller_pkg.sv
// Shared constants for the SRAM memory-stage controller.
// Contents: FSM state encodings, default base address, half-select values
// and the wait-counter width helper.
package sram_mem_controller_pkg;

  localparam logic [1:0] MEMC_IDLE = 2'd0;
  localparam logic [1:0] MEMC_LOW  = 2'd1;
  localparam logic [1:0] MEMC_HIGH = 2'd2;
  localparam logic [1:0] MEMC_DONE = 2'd3;

  localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;

  localparam logic HALF_LOW  = 1'b0;
  localparam logic HALF_HIGH = 1'b1;

  // Zero wait cycles would give a zero-width counter; keep at least one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_mem_controller_wait_counter.sv
// Phase-length timer for the SRAM controller.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   start      : load WAIT_CYCLES (first cycle of the new phase follows)
//   last       : high on the final cycle of the current phase
module mem_wait_counter
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic last
);

  localparam int unsigned CW = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit accesses on an
// external asynchronous SRAM, holding ready low while the access is in flight.
// Ports:
//   clk, rst_n            : clock and synchronous active-low reset
//   mem_read, mem_write   : request strobes (write wins if both are high)
//   address, write_data   : byte address and store data
//   read_data             : registered load result
//   ready                 : low while an access is pending (freeze = !ready)
//   sram_addr             : half-word address {word_addr, half}
//   sram_dq_out/oe/in     : SRAM data bus pieces (tristate built above)
//   sram_we_n             : SRAM write enable, active-low
//
// state | meaning
// IDLE  | waiting for a request; latches op, address, data
// LOW   | accessing half-word 0 for WAIT_CYCLES+1 cycles
// HIGH  | accessing half-word 1 for WAIT_CYCLES+1 cycles
// DONE  | one cycle, ready high, read_data valid
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  logic [1:0]             state;
  logic                   op_write;
  logic [SRAM_ADDR_W-2:0] word_addr;
  logic [SRAM_ADDR_W-2:0] word_addr_in;
  logic [31:0]            wdata;
  logic                   request;
  logic                   last;
  logic                   start;

  assign request = mem_read | mem_write;

  // Unsigned subtraction; addresses below the base wrap silently.
  assign word_addr_in = (SRAM_ADDR_W-1)'((address - BASE_ADDR) >> 2);

  assign ready = ((state == MEMC_IDLE) && !request) || (state == MEMC_DONE);

  // Reload the timer on entry to each phase.
  assign start = ((state == MEMC_IDLE) && request) || ((state == MEMC_LOW) && last);

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .last (last)
  );

  // SRAM pins are registered and change on the same edge as the state, so
  // they are stable for every cycle of a phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= MEMC_IDLE;
      op_write    <= 1'b0;
      word_addr   <= '0;
      wdata       <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
    end else begin
      case (state)
        MEMC_IDLE: begin
          if (request) begin
            op_write    <= mem_write;
            word_addr   <= word_addr_in;
            wdata       <= write_data;
            sram_addr   <= {word_addr_in, HALF_LOW};
            sram_dq_out <= write_data[15:0];
            sram_we_n   <= !mem_write;
            sram_dq_oe  <= mem_write;
            state       <= MEMC_LOW;
          end
        end
        MEMC_LOW: begin
          if (last) begin
            if (!op_write) begin
              read_data[15:0] <= sram_dq_in;
            end
            sram_addr   <= {word_addr, HALF_HIGH};
            sram_dq_out <= wdata[31:16];
            state       <= MEMC_HIGH;
          end
        end
        MEMC_HIGH: begin
          if (last) begin
            if (!op_write) begin
              read_data[31:16] <= sram_dq_in;
            end
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            state      <= MEMC_DONE;
          end
        end
        default: begin
          state <= MEMC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Memory-stage responder for the core's `mem_read`/`mem_write` control strobes. It turns each 32-bit word load or store issued by the MEM stage into two sequential 16-bit accesses on an external asynchronous SRAM. While an access is in flight it holds `ready` low, and the hazard/freeze logic uses that to stall the whole pipeline.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM half-word 0.
- `SRAM_ADDR_W`, default 18: width of the SRAM half-word address.
- `WAIT_CYCLES`, default 1: extra hold cycles per half-access. Each phase lasts `WAIT_CYCLES+1` cycles.

Ports:
- `clk` in 1: single clock for all state.
- `rst_n` in 1: reset, synchronous and active-low.
- `mem_read` in 1: load request from the MEM stage.
- `mem_write` in 1: store request from the MEM stage.
- `address` in 32: byte address from the ALU result.
- `write_data` in 32: store data (the Rm value).
- `read_data` out 32: registered load result.
- `ready` out 1: high when no access is pending or the access completes this cycle. Freeze equals `!ready`.
- `sram_addr` out SRAM_ADDR_W: half-word address to the SRAM.
- `sram_dq_out` out 16: write data driven to the SRAM.
- `sram_dq_oe` out 1: data-bus output enable. The top level builds the tristate.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- FSM states: `IDLE`, `LOW`, `HIGH`, `DONE`.
- `IDLE`: when `mem_read | mem_write`, latch the operation, the word address and `write_data`, then go to `LOW`. Otherwise stay in `IDLE`.
- Write priority: if both strobes are high, the access is a write.
- Word address: `(address - BASE_ADDR) >> 2`, computed as an unsigned 32-bit subtraction and truncated to `SRAM_ADDR_W-1` bits. Addresses below the base wrap silently.
- SRAM half-word addressing:
  - Bit 0 of `sram_addr` selects the half: 0 = `LOW`, 1 = `HIGH`.
  - `sram_addr = {word_addr, half}`.
- `LOW` and `HIGH` each last `WAIT_CYCLES+1` cycles, counted by the wait counter.
- Write phase behaviour:
  - `sram_we_n = 0` for every cycle of the phase.
  - `sram_dq_oe = 1`.
  - `sram_dq_out` = `wdata[15:0]` in `LOW`, `wdata[31:16]` in `HIGH`.
- Read phase behaviour:
  - `sram_we_n = 1` and `sram_dq_oe = 0`.
  - On the last cycle of `LOW`, capture `sram_dq_in` into `read_data[15:0]`.
  - On the last cycle of `HIGH`, capture it into `read_data[31:16]`.
- `DONE`: one cycle. Then unconditionally return to `IDLE`.
- Outside the phases, the SRAM pins idle: `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr` holds its last value.
- `read_data` holds its value until the next read overwrites it. Writes never modify `read_data`.
- Request inputs are ignored outside `IDLE`, because the pipeline is frozen. Deasserting a request mid-access does not abort it.

## Timing
- `ready` is combinational: `(state==IDLE & !(mem_read|mem_write)) | (state==DONE)`. It drops in the same cycle a request appears.
- Request seen in `IDLE` at cycle 0:
  - `LOW` occupies cycles 1..W+1, where W = `WAIT_CYCLES`.
  - `HIGH` occupies cycles W+2..2W+2.
  - `DONE` is cycle 2W+3, with `ready=1` and `read_data` valid.
  - With W=1, `ready` is low for cycles 0–4 and high at cycle 5.
- Back-to-back requests: a request present in the cycle after `DONE` starts immediately from `IDLE`. No extra bubble.
- Reset values: state `IDLE`, `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_we_n=1`, `sram_dq_oe=0`, wait counter 0.
- Reset mid-access takes effect on the next rising edge:
  - The FSM returns to `IDLE` and `sram_we_n=1`.
  - A half-completed write leaves the SRAM partially updated. This is accepted.

## Structure
- Shared package / `constants.h`:
  - FSM state encodings (`MEMC_IDLE`, `MEMC_LOW`, `MEMC_HIGH`, `MEMC_DONE`, 2 bits).
  - Default `BASE_ADDR`.
  - Half-select constants.
- Sub-module `mem_wait_counter`: loadable down-counter of width `$clog2(WAIT_CYCLES+1)`. It has a `start` input and a `last` output, and the FSM uses `last` to advance phases.

## Test plan
1. Reset with `rst_n=0` for 2 cycles, with requests active → `ready` follows only the request, `sram_we_n=1`, `sram_dq_oe=0`, `read_data=0`.
2. Write with W=1: `address=1028`, `write_data=32'hDEADBEEF` → SRAM model half-addr 2 = `16'hBEEF`, half-addr 3 = `16'hDEAD`. `ready` is low for cycles 0–4 and high at cycle 5.
3. Read `address=1028` after scenario 2 → `read_data=32'hDEADBEEF` at the `DONE` cycle. The bus is never driven (`sram_dq_oe` stays 0).
4. Back-to-back: write 1032/`32'h12345678`, then a read of 1032 issued in the cycle after `DONE` → `read_data=32'h12345678`. No idle cycle between the two accesses.
5. Both strobes high, `address=1024`, `write_data=32'hA5A5_5A5A` → a write occurs, half-addrs 0/1 = `16'h5A5A`/`16'hA5A5`, and `read_data` is unchanged.
6. `rst_n` pulsed low during `HIGH` of a write → next cycle the state is `IDLE`, `sram_we_n=1`, `ready=1` with no request, and half-addr LOW holds the new data.
